sprite_line_scanner: RTL and testbench

- Read-side consumer of the sprite position memory.
- On each line-start pulse it walks all sprite indices on the memory read port (index out, 64-bit struct in) and tests each sprite for vertical overlap with the latched line.
- Overlapping sprites go into a small hit FIFO, which the pixel pipeline drains over a valid/ready stream.

---
 rtl/sprite_pkg.sv | 35 +++
 rtl/sprite_hit_fifo.sv | 63 ++++++
 rtl/sprite_line_scanner.sv | 183 ++++++++++++++++++
 tb/tb_sprite_line_scanner.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line scanner.
//   - Bit positions of the fields in the 64-bit sprite position word.
//   - Sprite index width (fixed at 5 bits, 32 sprites).
//   - Packed hit-entry type stored in the hit FIFO (45 bits).
//   - Scanner FSM state encoding.
package sprite_pkg;

   localparam int SPRITE_IDX_W = 5;

   // Sprite position word layout; bits [62:56] carry no information.
   localparam int X_LSB   = 0;
   localparam int Y_LSB   = 16;
   localparam int W_LSB   = 32;
   localparam int H_LSB   = 40;
   localparam int IMG_LSB = 48;
   localparam int EN_BIT  = 63;

   typedef struct packed {
      logic [SPRITE_IDX_W-1:0] idx;
      logic [15:0]             x;
      logic [7:0]              row;
      logic [7:0]              width;
      logic [7:0]              image;
   } hit_entry_t;

   localparam int HIT_ENTRY_W = $bits(hit_entry_t);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

endpackage

// File: rtl/sprite_hit_fifo.sv
// Synchronous FIFO holding the hits of the current line.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push_i/data_i: write one entry (ignored when full)
//   pop_i        : remove the head entry (ignored when empty)
//   flush_i      : empty the FIFO; takes priority over push and pop
//   valid_o      : head entry present
//   data_o       : head entry, forced to zero while empty
module sprite_hit_fifo #(
   parameter int WIDTH = 45,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign do_push = push_i && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         // Simultaneous push and pop leaves occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!reset && !flush_i && do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign valid_o = (count_q != '0);
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/sprite_line_scanner.sv
// Sprite line scanner: on each line-start pulse walks every sprite index on
// the position-memory read port, tests each sprite for vertical overlap with
// the latched line and queues up to MAX_HITS hits in ascending index order.
// Optional build macro: SPRITE_X_CLIP_EN (sprites with x >= SCREEN_WIDTH are
// not hits and do not consume a hit slot).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_line_start, i_line_y     : scan start pulse and the line to scan
//   o_spirit_idx               : memory read index
//   i_spirit_position_struct   : memory read data, READ_LATENCY cycles later
//   o_hit_valid, i_hit_ready   : hit stream handshake; a transfer (pop)
//                                happens on a clock edge where both are 1,
//                                ready while not valid has no effect
//   o_hit_idx/x/row/width/image: head hit entry
//   o_overflow                 : sticky, hits were dropped on this line
//   o_busy, o_scan_done        : scan in progress, scan completion pulse
module sprite_line_scanner
   import sprite_pkg::*;
#(
   parameter int SPRITE_COUNT = 32,
   parameter int MAX_HITS     = 8,
   parameter int READ_LATENCY = 1,
   parameter int SCREEN_WIDTH = 640
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_line_start,
   input  logic [15:0]             i_line_y,
   output logic [SPRITE_IDX_W-1:0] o_spirit_idx,
   input  logic [63:0]             i_spirit_position_struct,
   output logic                    o_hit_valid,
   input  logic                    i_hit_ready,
   output logic [SPRITE_IDX_W-1:0] o_hit_idx,
   output logic [15:0]             o_hit_x,
   output logic [7:0]              o_hit_row,
   output logic [7:0]              o_hit_width,
   output logic [7:0]              o_hit_image,
   output logic                    o_overflow,
   output logic                    o_busy,
   output logic                    o_scan_done
);

   localparam int                      CNT_W      = $clog2(MAX_HITS + 1);
   localparam logic [SPRITE_IDX_W-1:0] LAST_IDX   = SPRITE_IDX_W'(SPRITE_COUNT - 1);
   localparam logic [1:0]              DRAIN_LAST = 2'(READ_LATENCY - 1);

   scan_state_t             state_q;
   logic [SPRITE_IDX_W-1:0] idx_q;
   logic [15:0]             line_y_q;
   logic [CNT_W-1:0]        hit_cnt_q;
   logic                    overflow_q, busy_q, scan_done_q;
   logic [1:0]              drain_cnt_q;
   // One stage per cycle of read latency; the last stage lines up with the
   // returned memory word.
   logic [READ_LATENCY-1:0] rd_valid_q;
   logic [SPRITE_IDX_W-1:0] rd_idx_q [READ_LATENCY];

   logic [15:0] pos_x, pos_y;
   logic [7:0]  pos_w, pos_h, pos_img;
   logic        pos_en;
   logic [16:0] row_diff;
   logic        x_ok, sprite_hit, room, push;
   logic        unused_bits;
   hit_entry_t  new_entry, head_entry;

   assign pos_x   = i_spirit_position_struct[X_LSB +: 16];
   assign pos_y   = i_spirit_position_struct[Y_LSB +: 16];
   assign pos_w   = i_spirit_position_struct[W_LSB +: 8];
   assign pos_h   = i_spirit_position_struct[H_LSB +: 8];
   assign pos_img = i_spirit_position_struct[IMG_LSB +: 8];
   assign pos_en  = i_spirit_position_struct[EN_BIT];

`ifdef SPRITE_X_CLIP_EN
   assign x_ok        = ({16'd0, pos_x} < 32'(SCREEN_WIDTH));
   assign unused_bits = ^i_spirit_position_struct[62:56];
`else
   assign x_ok        = 1'b1;
   assign unused_bits = ^{i_spirit_position_struct[62:56], 32'(SCREEN_WIDTH)};
`endif

   // 17-bit subtract so a sprite below the line never wraps into a hit.
   assign row_diff   = {1'b0, line_y_q} - {1'b0, pos_y};
   assign sprite_hit = rd_valid_q[READ_LATENCY-1] && pos_en && x_ok &&
                       (line_y_q >= pos_y) && (row_diff < {9'd0, pos_h});
   assign room       = (hit_cnt_q < CNT_W'(MAX_HITS));
   // A data word consumed in a restart cycle belongs to the aborted line.
   assign push       = sprite_hit && room && !i_line_start;

   always_comb begin
      new_entry       = '0;
      new_entry.idx   = rd_idx_q[READ_LATENCY-1];
      new_entry.x     = pos_x;
      new_entry.row   = row_diff[7:0];
      new_entry.width = pos_w;
      new_entry.image = pos_img;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         line_y_q    <= '0;
         hit_cnt_q   <= '0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         scan_done_q <= 1'b0;
         drain_cnt_q <= '0;
         rd_valid_q  <= '0;
         for (int i = 0; i < READ_LATENCY; i++) rd_idx_q[i] <= '0;
      end else begin
         scan_done_q <= 1'b0;
         // A restart invalidates every read still in flight.
         rd_valid_q[0] <= (state_q == ST_SCAN) && !i_line_start;
         rd_idx_q[0]   <= idx_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            rd_valid_q[i] <= rd_valid_q[i-1] && !i_line_start;
            rd_idx_q[i]   <= rd_idx_q[i-1];
         end

         if (i_line_start) begin
            state_q     <= ST_SCAN;
            idx_q       <= '0;
            line_y_q    <= i_line_y;
            hit_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b1;
            drain_cnt_q <= '0;
         end else begin
            if (sprite_hit) begin
               if (room) hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
               else      overflow_q <= 1'b1;
            end
            case (state_q)
               ST_IDLE: ;
               ST_SCAN: begin
                  if (idx_q == LAST_IDX) begin
                     state_q     <= ST_DRAIN;
                     drain_cnt_q <= '0;
                  end else begin
                     idx_q <= idx_q + SPRITE_IDX_W'(1);
                  end
               end
               ST_DRAIN: begin
                  if (drain_cnt_q == DRAIN_LAST) begin
                     state_q     <= ST_DONE;
                     busy_q      <= 1'b0;
                     scan_done_q <= 1'b1;
                  end else begin
                     drain_cnt_q <= drain_cnt_q + 2'd1;
                  end
               end
               ST_DONE: state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   sprite_hit_fifo #(
      .WIDTH(HIT_ENTRY_W),
      .DEPTH(MAX_HITS)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (push),
      .data_i (new_entry),
      .pop_i  (i_hit_ready),
      .flush_i(i_line_start),
      .valid_o(o_hit_valid),
      .data_o (head_entry)
   );

   assign o_spirit_idx = idx_q;
   assign o_hit_idx    = head_entry.idx;
   assign o_hit_x      = head_entry.x;
   assign o_hit_row    = head_entry.row;
   assign o_hit_width  = head_entry.width;
   assign o_hit_image  = head_entry.image;
   assign o_overflow   = overflow_q;
   assign o_busy       = busy_q;
   assign o_scan_done  = scan_done_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
module tb_sprite_line_scanner;

   localparam int RL = 1;
`ifdef SPRITE_X_CLIP_EN
   localparam bit CLIP_ON = 1'b1;
`else
   localparam bit CLIP_ON = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        i_line_start;
   logic [15:0] i_line_y;
   logic [4:0]  o_spirit_idx;
   logic [63:0] rdata;
   logic        o_hit_valid, i_hit_ready;
   logic [4:0]  o_hit_idx;
   logic [15:0] o_hit_x;
   logic [7:0]  o_hit_row, o_hit_width, o_hit_image;
   logic        o_overflow, o_busy, o_scan_done;

   always #5 clk = ~clk;

   sprite_line_scanner #(
      .SPRITE_COUNT(32), .MAX_HITS(8), .READ_LATENCY(RL), .SCREEN_WIDTH(640)
   ) dut (
      .clk(clk), .reset(reset), .i_line_start(i_line_start), .i_line_y(i_line_y),
      .o_spirit_idx(o_spirit_idx), .i_spirit_position_struct(rdata),
      .o_hit_valid(o_hit_valid), .i_hit_ready(i_hit_ready), .o_hit_idx(o_hit_idx),
      .o_hit_x(o_hit_x), .o_hit_row(o_hit_row), .o_hit_width(o_hit_width),
      .o_hit_image(o_hit_image), .o_overflow(o_overflow), .o_busy(o_busy),
      .o_scan_done(o_scan_done)
   );

   // Sprite position memory with one cycle of read latency.
   logic [63:0] mem [32];
   always @(posedge clk) rdata <= mem[o_spirit_idx];

   // ---------------- scoreboard state ----------------
   logic [44:0] exp_q[$];
   logic [44:0] obs_q[$];
   bit          exp_ovf;
   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   bit          rand_ready = 1'b0;

   // Record every transfer on the hit stream (pop happens at the next edge).
   always @(negedge clk) begin
      if (!reset && o_hit_valid && i_hit_ready)
         obs_q.push_back({o_hit_idx, o_hit_x, o_hit_row, o_hit_width, o_hit_image});
      if (!reset && o_scan_done) done_cnt++;
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 i_hit_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] spr(input int x, input int y, input int w,
                                       input int h, input int img, input int en);
      return {en[0], 7'd0, img[7:0], h[7:0], w[7:0], y[15:0], x[15:0]};
   endfunction

   // Expected hits for a line: every enabled sprite whose rows include the
   // line, in index order, at most 8; any further hit sets overflow.
   function automatic void model(input int ly);
      logic [63:0] s;
      int sx, sy, sh, cnt;
      logic [7:0] row;
      exp_q.delete();
      exp_ovf = 1'b0;
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         s  = mem[i];
         sx = int'(s[15:0]);
         sy = int'(s[31:16]);
         sh = int'(s[47:40]);
         if (s[63] && ly >= sy && (ly - sy) < sh && (!CLIP_ON || sx < 640)) begin
            row = 8'(ly - sy);
            if (cnt < 8) begin
               exp_q.push_back({i[4:0], s[15:0], row, s[39:32], s[55:48]});
               cnt++;
            end else begin
               exp_ovf = 1'b1;
            end
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = 64'd0;
   endtask

   // Returns in the cycle after the start edge (index 0 on the bus).
   task automatic pulse_line(input int y);
      @(posedge clk); #1;
      i_line_start = 1'b1;
      i_line_y     = 16'(y);
      @(posedge clk); #1;
      i_line_start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (o_scan_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drain();
      i_hit_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (!o_hit_valid) break;
      end
      i_hit_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int d0;
      reset = 1'b1; i_line_start = 1'b0; i_line_y = '0; i_hit_ready = 1'b0;
      clear_mem();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (o_spirit_idx !== 5'd0) begin n_errors++; $display("FAIL reset_idx got %0d exp 0", o_spirit_idx); end
      n_checks++;
      if (o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", o_hit_valid); end
      n_checks++;
      if ({o_hit_idx, o_hit_x, o_hit_row, o_hit_width, o_hit_image} !== 45'd0) begin
         n_errors++; $display("FAIL reset_fields got %0h exp 0", {o_hit_idx, o_hit_x, o_hit_row, o_hit_width, o_hit_image});
      end
      n_checks++;
      if ({o_overflow, o_busy, o_scan_done} !== 3'b000) begin
         n_errors++; $display("FAIL reset_flags got %b exp 000", {o_overflow, o_busy, o_scan_done});
      end
      reset = 1'b0;

      // Reset in the middle of a scan: everything cleared, no done pulse.
      mem[0] = spr(0, 3, 8, 2, 1, 1);
      d0 = done_cnt;
      pulse_line(3);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      n_checks++;
      if ({o_busy, o_hit_valid, o_spirit_idx} !== 7'd0) begin
         n_errors++; $display("FAIL midscan_reset got %0h exp 0", {o_busy, o_hit_valid, o_spirit_idx});
      end
      repeat (40) @(posedge clk);
      #1;
      n_checks++;
      if (done_cnt != d0) begin n_errors++; $display("FAIL midscan_reset_done got %0d exp %0d", done_cnt, d0); end
   endtask

   task automatic test_index_walk();
      int d0;
      clear_mem();
      d0 = done_cnt;
      pulse_line(10);
      for (int k = 0; k < 32; k++) begin
         n_checks++;
         if (o_spirit_idx !== 5'(k) || o_busy !== 1'b1) begin
            n_errors++; $display("FAIL walk_idx got %0d busy %b exp %0d busy 1", o_spirit_idx, o_busy, k);
         end
         @(posedge clk); #1;
      end
      // Now in cycle t+33: drain, not yet done.
      n_checks++;
      if (o_scan_done !== 1'b0 || o_busy !== 1'b1) begin
         n_errors++; $display("FAIL walk_t33 got done %b busy %b exp done 0 busy 1", o_scan_done, o_busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (o_scan_done !== 1'b1 || o_busy !== 1'b0) begin
         n_errors++; $display("FAIL walk_t34 got done %b busy %b exp done 1 busy 0", o_scan_done, o_busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (o_hit_valid !== 1'b0 || o_overflow !== 1'b0 || done_cnt != d0 + 1) begin
         n_errors++; $display("FAIL walk_nohit got valid %b ovf %b dones %0d exp 0 0 %0d",
                              o_hit_valid, o_overflow, done_cnt - d0, 1);
      end
   endtask

   task automatic test_single_hit();
      bit ok;
      clear_mem();
      mem[3] = spr(100, 8, 16, 4, 7, 1);
      obs_q.delete();
      pulse_line(11);
      wait_done(ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL single_done got timeout exp done"); end
      n_checks++;
      if ({o_hit_valid, o_hit_idx, o_hit_x, o_hit_row, o_hit_width, o_hit_image} !== {1'b1, 5'd3, 16'd100, 8'd3, 8'd16, 8'd7}) begin
         n_errors++; $display("FAIL single_entry got v%b idx %0d x %0d row %0d w %0d img %0d exp v1 idx 3 x 100 row 3 w 16 img 7",
                              o_hit_valid, o_hit_idx, o_hit_x, o_hit_row, o_hit_width, o_hit_image);
      end
      i_hit_ready = 1'b1;
      @(posedge clk); #1 i_hit_ready = 1'b0;
      n_checks++;
      if (o_hit_valid !== 1'b0 || obs_q.size() != 1) begin
         n_errors++; $display("FAIL single_pop got valid %b pops %0d exp 0 1", o_hit_valid, obs_q.size());
      end
      // Line just past the sprite's last row.
      pulse_line(12);
      wait_done(ok);
      n_checks++;
      if (!ok || o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL below_sprite got valid %b ok %b exp 0 1", o_hit_valid, ok); end
      // Zero height never hits, even on the sprite's own top row.
      mem[3] = spr(100, 11, 16, 0, 7, 1);
      pulse_line(11);
      wait_done(ok);
      n_checks++;
      if (!ok || o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL zero_height got valid %b ok %b exp 0 1", o_hit_valid, ok); end
   endtask

   task automatic test_overflow();
      bit ok;
      clear_mem();
      for (int i = 0; i < 10; i++) mem[i] = spr(20 * i, 5, 8, 1, i + 40, 1);
      obs_q.delete();
      model(5);
      pulse_line(5);
      wait_done(ok);
      n_checks++;
      if (!ok || o_overflow !== 1'b1 || o_hit_valid !== 1'b1) begin
         n_errors++; $display("FAIL ovf_flags got ok %b ovf %b valid %b exp 1 1 1", ok, o_overflow, o_hit_valid);
      end
      drain();
      n_checks++;
      if (obs_q.size() != exp_q.size() || o_hit_valid !== 1'b0) begin
         n_errors++; $display("FAIL ovf_count got %0d valid %b exp %0d valid 0", obs_q.size(), o_hit_valid, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL ovf_entry%0d got %0h exp %0h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_abort();
      bit ok, seen;
      int d0;
      clear_mem();
      mem[5]  = spr(0, 20, 4, 1, 5, 1);
      mem[11] = spr(0, 20, 4, 1, 11, 1);
      mem[20] = spr(50, 30, 4, 2, 20, 1);
      obs_q.delete();
      d0 = done_cnt;
      pulse_line(20);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (o_spirit_idx == 5'd12) begin seen = 1'b1; break; end
         @(posedge clk); #1;
      end
      n_checks++;
      if (!seen || o_hit_valid !== 1'b1) begin n_errors++; $display("FAIL abort_setup got seen %b valid %b exp 1 1", seen, o_hit_valid); end
      // Restart while sprite 11's data is being consumed.
      i_line_start = 1'b1;
      i_line_y     = 16'd30;
      @(posedge clk); #1 i_line_start = 1'b0;
      n_checks++;
      if (o_spirit_idx !== 5'd0 || o_hit_valid !== 1'b0) begin
         n_errors++; $display("FAIL abort_restart got idx %0d valid %b exp 0 0", o_spirit_idx, o_hit_valid);
      end
      wait_done(ok);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (!ok || done_cnt != d0 + 1) begin n_errors++; $display("FAIL abort_dones got %0d exp 1", done_cnt - d0); end
      model(30);
      drain();
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL abort_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL abort_entry%0d got %0h exp %0h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_mem();
      for (int i = 1; i <= 3; i++) mem[i] = spr(10 * i, 40, 8, 3, i, 1);
      obs_q.delete();
      i_hit_ready = 1'b1;
      pulse_line(41);
      repeat (3) begin @(posedge clk); #1; end
      // Cycles t+4..t+6: each entry is popped as the next one is pushed.
      for (int k = 1; k <= 3; k++) begin
         n_checks++;
         if (o_hit_valid !== 1'b1 || o_hit_idx !== 5'(k) || o_hit_row !== 8'd1) begin
            n_errors++; $display("FAIL b2b_head got valid %b idx %0d row %0d exp 1 %0d 1", o_hit_valid, o_hit_idx, o_hit_row, k);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_empty got %b exp 0", o_hit_valid); end
      wait_done(ok);
      i_hit_ready = 1'b0;
      n_checks++;
      if (!ok || obs_q.size() != 3) begin n_errors++; $display("FAIL b2b_count got %0d ok %b exp 3 1", obs_q.size(), ok); end
   endtask

   task automatic test_clip();
      bit ok;
      clear_mem();
      mem[0] = spr(640, 60, 8, 2, 9, 1);
      for (int i = 1; i <= 8; i++) mem[i] = spr(639, 60, 8, 2, i, 1);
      obs_q.delete();
      model(61);
      pulse_line(61);
      wait_done(ok);
      n_checks++;
      if (!ok || o_overflow !== !CLIP_ON || o_hit_idx !== (CLIP_ON ? 5'd1 : 5'd0)) begin
         n_errors++; $display("FAIL clip_head got ovf %b idx %0d exp ovf %b idx %0d", o_overflow, o_hit_idx, !CLIP_ON, CLIP_ON ? 1 : 0);
      end
      drain();
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL clip_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL clip_entry%0d got %0h exp %0h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      bit ok;
      int ly;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < 32; i++)
            mem[i] = spr($urandom_range(0, 700), $urandom_range(0, 40), $urandom_range(1, 255),
                         $urandom_range(0, 12), $urandom_range(0, 255), ($urandom_range(0, 3) != 0) ? 1 : 0);
         ly = $urandom_range(0, 50);
         obs_q.delete();
         model(ly);
         rand_ready = 1'b1;
         pulse_line(ly);
         wait_done(ok);
         rand_ready = 1'b0;
         @(posedge clk); #2;
         n_checks++;
         if (!ok || o_overflow !== exp_ovf) begin
            n_errors++; $display("FAIL rand%0d_ovf got %b ok %b exp %b", it, o_overflow, ok, exp_ovf);
         end
         drain();
         n_checks++;
         if (obs_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rand%0d_entry%0d got %0h exp %0h", it, i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_index_walk();
      test_single_hit();
      test_overflow();
      test_abort();
      test_back_to_back();
      test_clip();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
